// File: rtl/wb_arbiter_2m_if.sv
// wb_arbiter_2m_if: bus bundle for the two-master Wishbone B3 arbiter.
//   wbs0_* / wbs1_* : local master ports (CPU = 0, DMA = 1)
//   wbm_*           : single Wishbone master port toward the bridge slave side
// Modports:
//   slave  : arbiter view (takes master requests, drives the bridge side)
//   master : environment view (drives masters and bridge responses)
interface wb_arbiter_2m_if;
  logic [31:0] wbs0_dat_i;
  logic [31:2] wbs0_adr_i;
  logic [3:0]  wbs0_sel_i;
  logic [1:0]  wbs0_bte_i;
  logic [2:0]  wbs0_cti_i;
  logic        wbs0_we_i;
  logic        wbs0_cyc_i;
  logic        wbs0_stb_i;
  logic [31:0] wbs0_dat_o;
  logic        wbs0_ack_o;
  logic        wbs0_err_o;

  logic [31:0] wbs1_dat_i;
  logic [31:2] wbs1_adr_i;
  logic [3:0]  wbs1_sel_i;
  logic [1:0]  wbs1_bte_i;
  logic [2:0]  wbs1_cti_i;
  logic        wbs1_we_i;
  logic        wbs1_cyc_i;
  logic        wbs1_stb_i;
  logic [31:0] wbs1_dat_o;
  logic        wbs1_ack_o;
  logic        wbs1_err_o;

  logic [31:0] wbm_dat_o;
  logic [31:2] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport slave (
    input  wbs0_dat_i, wbs0_adr_i, wbs0_sel_i, wbs0_bte_i, wbs0_cti_i,
           wbs0_we_i, wbs0_cyc_i, wbs0_stb_i,
    output wbs0_dat_o, wbs0_ack_o, wbs0_err_o,
    input  wbs1_dat_i, wbs1_adr_i, wbs1_sel_i, wbs1_bte_i, wbs1_cti_i,
           wbs1_we_i, wbs1_cyc_i, wbs1_stb_i,
    output wbs1_dat_o, wbs1_ack_o, wbs1_err_o,
    output wbm_dat_o, wbm_adr_o, wbm_sel_o, wbm_bte_o, wbm_cti_o,
           wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport master (
    output wbs0_dat_i, wbs0_adr_i, wbs0_sel_i, wbs0_bte_i, wbs0_cti_i,
           wbs0_we_i, wbs0_cyc_i, wbs0_stb_i,
    input  wbs0_dat_o, wbs0_ack_o, wbs0_err_o,
    output wbs1_dat_i, wbs1_adr_i, wbs1_sel_i, wbs1_bte_i, wbs1_cti_i,
           wbs1_we_i, wbs1_cyc_i, wbs1_stb_i,
    input  wbs1_dat_o, wbs1_ack_o, wbs1_err_o,
    input  wbm_dat_o, wbm_adr_o, wbm_sel_o, wbm_bte_o, wbm_cti_o,
           wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone B3 burst arbiter feeding the bridge.
// Round-robin between master 0 and 1, grant held for the whole cyc so bursts
// pass unbroken, and a per-grant ack watchdog that returns err on a stall.
// Ports:
//   wb_clk   : clock
//   wb_rst_n : asynchronous active-low reset
//   bus      : wb_arbiter_2m_if.slave (both local masters + bridge-side master)
// Parameters:
//   timeout   : granted stb cycles without ack before err (2..65535)
//   cnt_width : watchdog counter width, must hold timeout-1
module wb_arbiter_2m #(
  parameter int unsigned timeout   = 1024,
  parameter int unsigned cnt_width = 16
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  wb_arbiter_2m_if.slave  bus
);

  localparam int unsigned CntW = cnt_width;

  // Elaboration-time guard: the watchdog can never saturate if timeout-1 fits.
  if (timeout < 2 || timeout > 65535 || CntW == 0 || CntW > 32 ||
      64'(timeout - 1) >= (64'd1 << CntW)) begin : g_param_check
    $error("wb_arbiter_2m: timeout out of range or cnt_width too narrow");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;   // 0: master 0 wins a tie, 1: master 1 wins
  logic [CntW-1:0] wd_q, wd_d;
  logic            gnt_stb;
  logic            stall;
  logic            wd_term;

  // State, priority pointer and watchdog registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state: grant only changes when the owner drops cyc.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.wbs0_cyc_i && bus.wbs1_cyc_i) begin
          state_d = ptr_q ? GNT1 : GNT0;
          ptr_d   = ~ptr_q;
        end else if (bus.wbs0_cyc_i) begin
          state_d = GNT0;
        end else if (bus.wbs1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!bus.wbs0_cyc_i) begin
          if (bus.wbs1_cyc_i) begin
            state_d = GNT1;
            ptr_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (!bus.wbs1_cyc_i) begin
          if (bus.wbs0_cyc_i) begin
            state_d = GNT0;
            ptr_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts unacked granted strobes; terminal count fires err and rearms.
  always_comb begin
    gnt_stb = 1'b0;
    case (state_q)
      GNT0:    gnt_stb = bus.wbs0_stb_i;
      GNT1:    gnt_stb = bus.wbs1_stb_i;
      default: gnt_stb = 1'b0;
    endcase
    stall   = gnt_stb && !bus.wbm_ack_i;
    wd_term = stall && (wd_q == CntW'(timeout - 1));
    if ((state_d != state_q) || !stall || wd_term) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + CntW'(1);
    end
  end

  // Bus mux: the bridge sees only the granted master; responses go back to it alone.
  always_comb begin
    bus.wbm_dat_o  = '0;
    bus.wbm_adr_o  = '0;
    bus.wbm_sel_o  = '0;
    bus.wbm_bte_o  = 2'b00;
    bus.wbm_cti_o  = 3'b000;
    bus.wbm_we_o   = 1'b0;
    bus.wbm_cyc_o  = 1'b0;
    bus.wbm_stb_o  = 1'b0;
    bus.wbs0_ack_o = 1'b0;
    bus.wbs1_ack_o = 1'b0;
    bus.wbs0_err_o = 1'b0;
    bus.wbs1_err_o = 1'b0;
    bus.wbs0_dat_o = bus.wbm_dat_i;
    bus.wbs1_dat_o = bus.wbm_dat_i;
    case (state_q)
      GNT0: begin
        bus.wbm_dat_o  = bus.wbs0_dat_i;
        bus.wbm_adr_o  = bus.wbs0_adr_i;
        bus.wbm_sel_o  = bus.wbs0_sel_i;
        bus.wbm_bte_o  = bus.wbs0_bte_i;
        bus.wbm_cti_o  = bus.wbs0_cti_i;
        bus.wbm_we_o   = bus.wbs0_we_i;
        bus.wbm_cyc_o  = bus.wbs0_cyc_i;
        bus.wbm_stb_o  = bus.wbs0_stb_i;
        bus.wbs0_ack_o = bus.wbm_ack_i;
        bus.wbs0_err_o = wd_term;
      end
      GNT1: begin
        bus.wbm_dat_o  = bus.wbs1_dat_i;
        bus.wbm_adr_o  = bus.wbs1_adr_i;
        bus.wbm_sel_o  = bus.wbs1_sel_i;
        bus.wbm_bte_o  = bus.wbs1_bte_i;
        bus.wbm_cti_o  = bus.wbs1_cti_i;
        bus.wbm_we_o   = bus.wbs1_we_i;
        bus.wbm_cyc_o  = bus.wbs1_cyc_i;
        bus.wbm_stb_o  = bus.wbs1_stb_i;
        bus.wbs1_ack_o = bus.wbm_ack_i;
        bus.wbs1_err_o = wd_term;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master Wishbone B3 burst arbiter that sits directly upstream of the clock-domain bridge's slave port.
- Multiplexes two local masters (CPU and DMA) onto one Wishbone master interface that feeds the bridge.
- Grant is held for the whole cycle (cyc high), so incrementing and wrapping bursts (cti/bte) pass through unbroken.
- Round-robin fairness, plus a per-grant ack watchdog that returns err to a master whose slave never answers.

Parameters:
- timeout, 1024: cycles of granted stb without ack before err is returned (range 2..65535).
- cnt_width, 16: width of the watchdog counter; must hold timeout-1.

Ports:
- wb_clk  in  1  single clock for all logic.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wbs0_dat_i / wbs1_dat_i  in  32  write data from master 0 / 1.
- wbs0_adr_i / wbs1_adr_i  in  [31:2]  word address.
- wbs0_sel_i / wbs1_sel_i  in  4  byte selects.
- wbs0_bte_i / wbs1_bte_i  in  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16).
- wbs0_cti_i / wbs1_cti_i  in  3  cycle type (000 classic, 010 incburst, 111 endofburst).
- wbs0_we_i, wbs0_cyc_i, wbs0_stb_i / wbs1_*  in  1 each  master controls.
- wbs0_dat_o / wbs1_dat_o  out  32  read data, a copy of wbm_dat_i.
- wbs0_ack_o / wbs1_ack_o  out  1  ack, routed to the granted master only.
- wbs0_err_o / wbs1_err_o  out  1  watchdog error pulse.
- wbm_dat_o, wbm_adr_o[31:2], wbm_sel_o, wbm_bte_o, wbm_cti_o, wbm_we_o, wbm_cyc_o, wbm_stb_o  out  32/30/4/2/3/1/1/1  to bridge slave side.
- wbm_dat_i  in  32  read data from bridge.
- wbm_ack_i  in  1  ack from bridge.

Behaviour:
- Async reset (wb_rst_n low):
  - state=IDLE, priority pointer=master 0, watchdog=0.
  - All outputs 0; wbm_cti_o=classic, wbm_bte_o=linear.
  - Reset mid-burst drops wbm_cyc_o/stb_o in the same instant. No recovery of the aborted transfer.
- States are IDLE, GNT0, GNT1 (registered).
  - IDLE: if exactly one master has cyc high, grant it next cycle. If both, grant the pointer master and move the pointer to the other master.
- Arbitration latency: cyc seen high in cycle n -> state GNTx and wbm_cyc_o high in cycle n+1. Ungranted masters see no ack and no err.
- GNTx: wbm_* outputs are a combinational mux of master x; wbm_cyc_o=wbsx_cyc_i, wbm_stb_o=wbsx_stb_i.
  - wbsx_ack_o = wbm_ack_i; wbsx_dat_o = wbm_dat_i.
  - Other master: ack=0, err=0; its dat_o is don't-care (driven = wbm_dat_i).
- Release: when the granted master's cyc is low in GNTx.
  - If the other master's cyc is high in that same cycle, go directly to GNT(other) and move the pointer away from it (no IDLE bubble).
  - Otherwise go to IDLE.
  - While not granted, wbm_cyc_o=0 and wbm_stb_o=0.
- Burst integrity: grant never changes while the granted cyc is high, whatever cti/bte or requests from the other master.
- Watchdog:
  - Counts cycles in GNTx with stb high and wbm_ack_i low.
  - Clears on ack, on stb low, and on any state change.
  - When the count reaches timeout-1 with no ack that cycle: pulse wbsx_err_o for 1 cycle, clear the counter, keep the grant. The master must drop cyc.
  - An ack in the terminal cycle wins: no err.
  - Saturation is impossible; width is checked by assertion.
- wbm_ack_i while in IDLE is ignored (not routed).
- Bridge back-pressure (ack withheld while its FIFO is full) only stretches the cycle. Counts toward the watchdog.

Test Plan:
- Single master 0 classic write, adr=0x100>>2, dat=0xDEADBEEF, ack after 3 cycles -> wbm_cyc_o high 1 cycle after wbs0_cyc_i; outputs mirror master 0; wbs0_ack_o pulses once; wbs1_ack_o stays 0.
- Both cyc rise in the same cycle after reset -> master 0 granted first. It drops cyc; master 1 is granted the next cycle with no IDLE cycle. Repeat with both requesting -> master 0 granted again (alternation).
- Master 1 wrap8 read burst (bte=10, cti=010 x7 then 111) while master 0 requests from the 2nd beat -> 8 acks to master 1, grant unchanged; master 0 granted in the cycle after wbs1_cyc_i falls.
- timeout=4, master 0 stb held high, no ack -> wbs0_err_o pulses on the 4th stb cycle and every 4 cycles after; an ack arriving on a 4th cycle suppresses that err.
- Assert wb_rst_n=0 mid-burst in GNT1 -> wbm_cyc_o/stb_o/acks/errs go 0 immediately; after release, master 0 holds priority.
- Stray wbm_ack_i in IDLE -> no ack on either master port; state remains IDLE.
